// File: rtl/synth_pkg.sv
// synth_pkg
//   Shared constants and types for the note sequencer and its tick generator.
//   - NOTE_W / DUR_W / DEPTH : pattern entry geometry
//   - NOTE_REST / DUR_END    : reserved codes (rest note, end-of-pattern)
//   - seq_state_e            : sequencer FSM states
//   - entry_t                : one pattern RAM word {note, dur}
//   - sel_div()              : picks the latched tick divider
package synth_pkg;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 4;
   localparam int DEPTH  = 32;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int DIV_W  = 21;

   localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
   localparam logic [DUR_W-1:0]  DUR_END   = 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2,
      GAP  = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  dur;
   } entry_t;

   // A zero tempo request falls back to the build-time default divider.
   function automatic logic [DIV_W-1:0] sel_div(input logic [DIV_W-1:0] tempo,
                                                input logic [DIV_W-1:0] dflt);
      logic [DIV_W-1:0] res;
      if (tempo == {DIV_W{1'b0}}) begin
         res = dflt;
      end else begin
         res = tempo;
      end
      return res;
   endfunction

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// tick_gen
//   Enable-pulse divider: a free-running count that pulses tick for one
//   cycle when it reaches div-1, then wraps. No derived clock is produced.
//   Ports:
//     clk    in   system clock
//     resetn in   synchronous active-low reset
//     clr    in   hold the count at zero
//     div    in   cycles per tick (must be >= 1 when clr is low)
//     tick   out  one-cycle pulse when count = div-1
module tick_gen
   import synth_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;

   // Pulse decode straight from the count flop.
   assign tick = (count_q == (div - {{(DIV_W-1){1'b0}}, 1'b1}));

   // Next count: cleared on request, wraps on tick, otherwise increments.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {DIV_W{1'b0}};
      end else if (tick) begin
         count_d = {DIV_W{1'b0}};
      end else begin
         count_d = count_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q <= {DIV_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a pattern of {note, dur} entries from an internal RAM, pacing the
//   pattern with a programmable tick enable and driving note/gate of a voice.
//   Parameter:
//     TICK_DIV  default cycles per tick, used when tempo_div = 0
//   Ports:
//     CLOCK_50  in   system clock
//     resetn    in   synchronous active-low reset
//     start     in   begin playback from index 0 when idle
//     stop      in   abort playback (wins over start)
//     loop_en   in   wrap from the last entry to index 0
//     tempo_div in   cycles per tick, latched at start
//     wr_en     in   pattern RAM write strobe (accepted only when idle)
//     wr_addr   in   write address
//     wr_data   in   {note, dur}
//     note      out  current note code
//     gate      out  high while a non-rest note sounds
//     tick      out  one-cycle tick pulse during PLAY/GAP
//     busy      out  high in LOAD, PLAY and GAP
//     step_idx  out  index of the current entry
//     done      out  one-cycle pulse on natural completion
module note_sequencer
   import synth_pkg::*;
#(
   parameter int TICK_DIV = 1250000
)
(
   input  logic                    CLOCK_50,
   input  logic                    resetn,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    loop_en,
   input  logic [DIV_W-1:0]        tempo_div,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_addr,
   input  logic [NOTE_W+DUR_W-1:0] wr_data,
   output logic [NOTE_W-1:0]       note,
   output logic                    gate,
   output logic                    tick,
   output logic                    busy,
   output logic [IDX_W-1:0]        step_idx,
   output logic                    done
);

   localparam logic [DIV_W-1:0] DFLT_DIV = DIV_W'(TICK_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

   seq_state_e        state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [IDX_W-1:0]  step_idx_q, step_idx_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              gate_q, gate_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DUR_W-1:0]  tcnt_q, tcnt_d;
   logic [DUR_W-1:0]  dur_q, dur_d;

   entry_t            ram_mem [DEPTH];
   entry_t            rd_q;
   logic              wr_ok_s;
   logic              clr_s;
   logic              tick_raw_s;
   logic              tick_s;

   // Writes land only while idle so a playing pattern never changes under us.
   assign wr_ok_s = wr_en && (state_q == IDLE);

   // Counter is held at zero outside PLAY/GAP, which also clears it in LOAD.
   assign clr_s   = (state_q == IDLE) || (state_q == LOAD);

   // With div=1 the raw decode is high while cleared, so qualify by state.
   assign tick_s  = tick_raw_s && ((state_q == PLAY) || (state_q == GAP));

   tick_gen u_tick_gen (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .clr    (clr_s),
      .div    (div_q),
      .tick   (tick_raw_s)
   );

   // Pattern RAM with a registered read of the next step index; a write to
   // that address in the same cycle forwards, so start+write reads new data.
   always_ff @(posedge CLOCK_50) begin
      if (wr_ok_s) begin
         ram_mem[wr_addr] <= entry_t'(wr_data);
      end
      if (wr_ok_s && (wr_addr == step_idx_d)) begin
         rd_q <= entry_t'(wr_data);
      end else begin
         rd_q <= ram_mem[step_idx_d];
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      step_idx_d = step_idx_q;
      note_d     = note_q;
      gate_d     = gate_q;
      done_d     = 1'b0;
      tcnt_d     = tcnt_q;
      dur_d      = dur_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d    = LOAD;
               div_d      = sel_div(tempo_div, DFLT_DIV);
               step_idx_d = {IDX_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            tcnt_d = {DUR_W{1'b0}};
            dur_d  = rd_q.dur;
            if (stop) begin
               state_d = IDLE;
            end else if (rd_q.dur == DUR_END) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = PLAY;
               note_d  = rd_q.note;
               gate_d  = (rd_q.note != NOTE_REST);
            end
         end
         PLAY: begin
            if (stop) begin
               state_d = IDLE;
            end else if (tick_s) begin
               // Count ticks spent in PLAY; the dur-th one ends the note.
               if ((tcnt_q + DUR_ONE) == dur_q) begin
                  state_d = GAP;
                  gate_d  = 1'b0;
                  tcnt_d  = {DUR_W{1'b0}};
               end else begin
                  tcnt_d = tcnt_q + DUR_ONE;
               end
            end else begin
               state_d = PLAY;
            end
         end
         GAP: begin
            if (stop) begin
               state_d = IDLE;
            end else if (tick_s) begin
               if (step_idx_q != IDX_LAST) begin
                  state_d    = LOAD;
                  step_idx_d = step_idx_q + IDX_ONE;
               end else if (loop_en) begin
                  state_d    = LOAD;
                  step_idx_d = {IDX_W{1'b0}};
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state, so an abort silences
      // the voice on the very next cycle.
      if (state_d == IDLE) begin
         note_d = NOTE_REST;
         gate_d = 1'b0;
      end else begin
         note_d = note_d;
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q    <= IDLE;
         div_q      <= {DIV_W{1'b0}};
         step_idx_q <= {IDX_W{1'b0}};
         note_q     <= NOTE_REST;
         gate_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tcnt_q     <= {DUR_W{1'b0}};
         dur_q      <= {DUR_W{1'b0}};
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         step_idx_q <= step_idx_d;
         note_q     <= note_d;
         gate_q     <= gate_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tcnt_q     <= tcnt_d;
         dur_q      <= dur_d;
      end
   end

   assign note     = note_q;
   assign gate     = gate_q;
   assign tick     = tick_s;
   assign busy     = busy_q;
   assign step_idx = step_idx_q;
   assign done     = done_q;

endmodule
